pipe_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Merges three hazard sources into one set of per-stage write enables and flushes:
  - load-use stall and branch flush from the hazard detection unit;
  - data-memory wait;
  - an internal FSM that tracks the multi-cycle multiply/divide unit.
- Interlocks HI/LO readers and new mult/div ops in ID until the running op retires.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/md_seq.sv | 92 +++++++++
 rtl/pipe_stall_ctrl.sv | 82 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types and default latencies for the pipeline stall control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

endpackage

`default_nettype wire

// File: rtl/md_seq.sv
// ============================================================================
// Module : md_seq
// Brief  : Multiply/divide unit tracker: IDLE/RUN/DONE FSM with down-counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module md_seq
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_div_i,
  input  logic hold_i,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] load;
  logic             accept;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  // A start held under a memory wait is frozen in EX, so it is only taken once
  assign accept = start_i & ~hold_i;
  assign load   = is_div_i ? DIV_LOAD : MUL_LOAD;
  assign cnt_d  = cnt_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            cnt_q  <= load;
            busy_q <= 1'b1;
            // Minimum latency skips RUN and writes HI/LO on the next cycle
            if (load == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            err_q <= 1'b1;
          end
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module : pipe_stall_ctrl
// Brief  : Per-stage write enables and flushes for the 5-stage pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic LD_Stall,
  input  logic BR_Flush,
  input  logic Mem_Wait,
  input  logic EX_MDStart,
  input  logic EX_MDIsDiv,
  input  logic ID_UsesHiLo,
  input  logic ID_IsMD,
  output logic PCWrite,
  output logic IF_IDWrite,
  output logic ID_EXWrite,
  output logic EX_MEMWrite,
  output logic MEM_WBWrite,
  output logic IF_Flush,
  output logic ID_Flush,
  output logic MD_Busy,
  output logic MD_Done,
  output logic MD_Err
);

  logic md_hazard;

  md_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_seq (
    .clk      (clk),
    .rst      (rst),
    .start_i  (EX_MDStart),
    .is_div_i (EX_MDIsDiv),
    .hold_i   (Mem_Wait),
    .busy_o   (MD_Busy),
    .done_o   (MD_Done),
    .err_o    (MD_Err)
  );

  // No HI/LO forwarding: readers and new ops wait until the unit is back in IDLE
  assign md_hazard = MD_Busy & (ID_UsesHiLo | ID_IsMD);

  always_comb begin
    PCWrite     = 1'b1;
    IF_IDWrite  = 1'b1;
    ID_EXWrite  = 1'b1;
    EX_MEMWrite = 1'b1;
    MEM_WBWrite = 1'b1;
    IF_Flush    = 1'b0;
    ID_Flush    = 1'b0;
    if (Mem_Wait) begin
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXWrite  = 1'b0;
      EX_MEMWrite = 1'b0;
      MEM_WBWrite = 1'b0;
    end else if (BR_Flush) begin
      IF_Flush = 1'b1;
      ID_Flush = 1'b1;
    end else if (md_hazard || LD_Stall) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_Flush   = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// Module : tb_pipe_stall_ctrl
// Brief  : Scoreboard bench for pipe_stall_ctrl against a cycle-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst, ld, br, mw, start, isdiv, uses, ismd;
  logic PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite;
  logic IF_Flush, ID_Flush, MD_Busy, MD_Done, MD_Err;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .LD_Stall(ld), .BR_Flush(br), .Mem_Wait(mw),
    .EX_MDStart(start), .EX_MDIsDiv(isdiv), .ID_UsesHiLo(uses), .ID_IsMD(ismd),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .ID_EXWrite(ID_EXWrite),
    .EX_MEMWrite(EX_MEMWrite), .MEM_WBWrite(MEM_WBWrite), .IF_Flush(IF_Flush),
    .ID_Flush(ID_Flush), .MD_Busy(MD_Busy), .MD_Done(MD_Done), .MD_Err(MD_Err)
  );

  // Bit order: PC IFID IDEX EXMEM MEMWB IFF IDF Busy Done Err
  wire [9:0] act_vec = {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite,
                        IF_Flush, ID_Flush, MD_Busy, MD_Done, MD_Err};

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] act_q[$];

  bit m_busy, m_done, m_err;
  int m_rem;

  function automatic logic [9:0] model_out();
    logic [6:0] pipe;
    logic haz;
    haz = m_busy && (uses || ismd);
    if (mw)             pipe = 7'b0000000;
    else if (br)        pipe = 7'b1111111;
    else if (haz || ld) pipe = 7'b0011101;
    else                pipe = 7'b1111100;
    return {pipe, m_busy, m_done, m_err};
  endfunction

  // Model counts edges remaining until HI/LO is written
  function automatic void model_step();
    bit acc;
    acc = start && !mw;
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_rem = 0;
    end else if (m_busy && !m_done) begin
      if (acc) m_err = 1;
      m_rem = m_rem - 1;
      if (m_rem == 0) m_done = 1;
    end else if (acc) begin
      m_busy = 1;
      m_rem  = isdiv ? DIV_LAT - 2 : MUL_LAT - 2;
      m_done = (m_rem == 0);
    end else begin
      m_busy = 0; m_done = 0;
    end
  endfunction

  task automatic drive(input bit s, input bit d, input bit w, input bit b,
                       input bit l, input bit u, input bit m);
    start = s; isdiv = d; mw = w; br = b; ld = l; uses = u; ismd = m;
  endtask

  task automatic tick();
    exp_q.push_back(model_out());
    @(negedge clk);
    act_q.push_back(act_vec);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e, a;
    rst = 1'b1;
    repeat (2) begin
      drive($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
            $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1));
      @(posedge clk); #1;
    end
    drive(0,0,0,0,0,0,0);
    m_busy = 0; m_done = 0; m_err = 0; m_rem = 0;
    tick();
    rst = 1'b0;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset: got %b expected %b", a, e); end
    end
    checks++;
    if (act_vec !== 10'b1111100000) begin
      errors++; $display("FAIL reset_defaults: got %b expected %b", act_vec, 10'b1111100000);
    end
  endtask

  task automatic test_mult(input bit hilo);
    logic [9:0] e, a;
    int done_at = -1;
    drive(1,0,0,0,0,hilo,0);
    tick();
    drive(0,0,0,0,0,hilo,0);
    repeat (6) tick();
    for (int k = 0; exp_q.size() > 0 && act_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a[1] === 1'b1) done_at = k;
      if (a !== e) begin errors++; $display("FAIL mult hilo=%0d cyc %0d: got %b expected %b", hilo, k, a, e); end
    end
    checks++;
    if (done_at != MUL_LAT - 1) begin
      errors++; $display("FAIL mult_done_cycle: got %0d expected %0d", done_at, MUL_LAT - 1);
    end
  endtask

  task automatic test_div_memwait();
    logic [9:0] e, a;
    int done_at = -1;
    for (int c = 0; c < 36; c++) begin
      drive(c <= 1, 1, (c == 0) || (c >= 10 && c <= 15), 0, 0, c[0], 0);
      tick();
    end
    for (int k = 0; exp_q.size() > 0 && act_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a[1] === 1'b1) done_at = k;
      if (a !== e) begin errors++; $display("FAIL div_memwait cyc %0d: got %b expected %b", k, a, e); end
    end
    checks++;
    if (done_at != 1 + DIV_LAT - 1) begin
      errors++; $display("FAIL div_done_cycle: got %0d expected %0d", done_at, DIV_LAT);
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] e, a;
    drive(1,0,0,0,0,0,0); tick();
    drive(0,0,0,1,1,1,0); tick();
    drive(0,0,1,1,1,1,1); tick();
    drive(0,0,0,0,0,0,0); repeat (4) tick();
    for (int k = 0; exp_q.size() > 0 && act_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (k == 1 && a[9:3] !== 7'b1111111) begin
        errors++; $display("FAIL simul_branch_wins: got %b expected %b", a[9:3], 7'b1111111);
      end
      if (a !== e) begin errors++; $display("FAIL simultaneous cyc %0d: got %b expected %b", k, a, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e, a;
    for (int c = 0; c < 14; c++) begin
      drive(c == 0 || c == 3 || c == 4, 0, 0, 0, 0, 0, 0);
      tick();
    end
    for (int k = 0; exp_q.size() > 0 && act_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (k == 4 && a[2] !== 1'b1) begin
        errors++; $display("FAIL b2b_no_idle_gap: got busy %b expected 1", a[2]);
      end
      if (a !== e) begin errors++; $display("FAIL back_to_back cyc %0d: got %b expected %b", k, a, e); end
    end
    checks++;
    if (MD_Err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", MD_Err); end
  endtask

  task automatic test_reset_mid_div();
    logic [9:0] e, a;
    int dones = 0;
    for (int c = 0; c < 40; c++) begin
      drive(c == 0, 1, 0, 0, 0, 1, 0);
      rst = (c == 5);
      tick();
    end
    rst = 1'b0;
    for (int k = 0; exp_q.size() > 0 && act_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (k > 5 && a[1] === 1'b1) dones++;
      if (a !== e) begin errors++; $display("FAIL reset_mid_div cyc %0d: got %b expected %b", k, a, e); end
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL mid_div_no_done: got %0d pulses expected 0", dones); end
  endtask

  task automatic test_random();
    logic [9:0] e, a;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0,5) == 0, $urandom_range(0,3) == 0, $urandom_range(0,4) == 0,
            $urandom_range(0,6) == 0, $urandom_range(0,5) == 0, $urandom_range(0,2) == 0,
            $urandom_range(0,3) == 0);
      rst = ($urandom_range(0,99) == 0);
      tick();
    end
    rst = 1'b0;
    for (int k = 0; exp_q.size() > 0 && act_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL random cyc %0d: got %b expected %b", k, a, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0,0,0,0,0,0,0);
    test_reset();
    test_mult(1'b0);
    test_mult(1'b1);
    test_div_memwait();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
